// File: rtl/cp0_except_unit.sv
// CP0 exception unit: prioritises MEM-stage exception/return flags, drives flush/redirect,
// and owns CP0 regs 8/9/11/12/13/14. Define CP0_TIMER_EN to build the Count/Compare timer.
module cp0_except_unit #(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
   parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        validM,
   input  logic [31:0] pcM,
   input  logic        in_delayslotM,
   input  logic [31:0] bad_addrM,
   input  logic        adelM,
   input  logic        adesM,
   input  logic        syscallM,
   input  logic        breakM,
   input  logic        riM,
   input  logic        overflowM,
   input  logic        eretM,
   input  logic [5:0]  int_i,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [4:0]  raddr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        flush,
   output logic [31:0] newpc,
   output logic [4:0]  excode,
   output logic [31:0] status_o,
   output logic [31:0] cause_o,
   output logic [31:0] epc_o
);

   typedef enum logic [4:0] {
      EXC_INT  = 5'h00,
      EXC_ADEL = 5'h04,
      EXC_ADES = 5'h05,
      EXC_SYS  = 5'h08,
      EXC_BP   = 5'h09,
      EXC_RI   = 5'h0a,
      EXC_OV   = 5'h0c
   } excCode_e;

   localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

   logic [31:0] status, cause, epc, badVAddr, count, compare;
   logic [31:0] badVAddrNext;
   logic        excTaken, eretTaken, setBadVAddr, intPending, exl, wrEn, tiNext;
   excCode_e    excCode;

   assign exl        = status[1];
   assign intPending = status[0] & ~exl & (|(cause[15:8] & status[15:8]));

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      excTaken     = 1'b0;
      eretTaken    = 1'b0;
      setBadVAddr  = 1'b0;
      badVAddrNext = bad_addrM;
      excCode      = EXC_INT;
      // Gating on rst makes flush drop the moment reset asserts, mid-cycle included.
      if (validM && !rst) begin
         if (intPending) begin
            excTaken = 1'b1;
            excCode  = EXC_INT;
         end else if (pcM[1:0] != 2'b00) begin
            excTaken     = 1'b1;
            excCode      = EXC_ADEL;
            setBadVAddr  = 1'b1;
            badVAddrNext = pcM;
         end else if (riM) begin
            excTaken = 1'b1;
            excCode  = EXC_RI;
         end else if (syscallM) begin
            excTaken = 1'b1;
            excCode  = EXC_SYS;
         end else if (breakM) begin
            excTaken = 1'b1;
            excCode  = EXC_BP;
         end else if (overflowM) begin
            excTaken = 1'b1;
            excCode  = EXC_OV;
         end else if (adelM) begin
            excTaken    = 1'b1;
            excCode     = EXC_ADEL;
            setBadVAddr = 1'b1;
         end else if (adesM) begin
            excTaken    = 1'b1;
            excCode     = EXC_ADES;
            setBadVAddr = 1'b1;
         end else if (eretM) begin
            eretTaken = 1'b1;
         end
      end
   end

   assign flush  = excTaken | eretTaken;
   assign newpc  = excTaken ? EXC_VECTOR : (eretTaken ? epc : 32'd0);
   assign excode = excTaken ? excCode : EXC_INT;
   assign wrEn   = we_i & ~excTaken;

   // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         status <= STATUS_RST;
      end else if (excTaken) begin
         status[1] <= 1'b1;
      end else if (eretTaken) begin
         status[1] <= 1'b0;
      end else if (wrEn && waddr_i == 5'd12) begin
         status <= (status & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
      end
   end

`ifdef CP0_TIMER_EN
   logic tick;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick    <= 1'b0;
         count   <= 32'd0;
         compare <= 32'd0;
      end else begin
         tick <= ~tick;
         if (wrEn && waddr_i == 5'd9) count <= data_i;
         else if (tick)               count <= count + 32'd1;
         if (wrEn && waddr_i == 5'd11) compare <= data_i;
      end
   end

   assign tiNext = (wrEn && waddr_i == 5'd11) ? 1'b0
                 : (cause[30] | ((count == compare) && (compare != 32'd0)));
`else
   assign count   = 32'd0;
   assign compare = 32'd0;
   assign tiNext  = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cause <= 32'd0;
      end else begin
         cause[30]    <= tiNext;
         cause[15:10] <= int_i | {cause[30], 5'b0};
         if (excTaken) begin
            if (!exl) cause[31] <= in_delayslotM;
            cause[6:2] <= excCode;
         end else if (wrEn && waddr_i == 5'd13) begin
            cause[9:8] <= data_i[9:8];
         end
      end
   end

   // A nested exception (EXL already set) keeps the original return address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         epc      <= 32'd0;
         badVAddr <= 32'd0;
      end else begin
         if (excTaken && !exl)                   epc <= in_delayslotM ? pcM - 32'd4 : pcM;
         else if (wrEn && waddr_i == 5'd14)      epc <= data_i;
         if (excTaken && setBadVAddr)            badVAddr <= badVAddrNext;
      end
   end

   always_comb begin
      case (raddr_i)
         5'd8:    data_o = badVAddr;
         5'd9:    data_o = count;
         5'd11:   data_o = compare;
         5'd12:   data_o = status;
         5'd13:   data_o = cause;
         5'd14:   data_o = epc;
         default: data_o = 32'd0;
      endcase
   end

   assign status_o = status;
   assign cause_o  = cause;
   assign epc_o    = epc;

endmodule

// File: tb/tb_cp0_except_unit.sv
// Self-checking bench for cp0_except_unit: directed scenarios plus a randomized run
// against a field-level CP0 model. Timer checks follow CP0_TIMER_EN.
module tb_cp0_except_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        validM, in_delayslotM, adelM, adesM, syscallM, breakM, riM, overflowM, eretM, we_i;
   logic [31:0] pcM, bad_addrM, data_i, data_o, newpc, status_o, cause_o, epc_o;
   logic [5:0]  int_i;
   logic [4:0]  waddr_i, raddr_i, excode;
   logic        flush;
   int          errors = 0;
   int          checks = 0;

   cp0_except_unit dut (
      .clk(clk), .rst(rst), .validM(validM), .pcM(pcM), .in_delayslotM(in_delayslotM),
      .bad_addrM(bad_addrM), .adelM(adelM), .adesM(adesM), .syscallM(syscallM), .breakM(breakM),
      .riM(riM), .overflowM(overflowM), .eretM(eretM), .int_i(int_i), .we_i(we_i),
      .waddr_i(waddr_i), .raddr_i(raddr_i), .data_i(data_i), .data_o(data_o), .flush(flush),
      .newpc(newpc), .excode(excode), .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o)
   );

   always #5 clk = ~clk;

   task automatic clearIn();
      validM = 0; in_delayslotM = 0; adelM = 0; adesM = 0; syscallM = 0; breakM = 0;
      riM = 0; overflowM = 0; eretM = 0; we_i = 0; int_i = '0; waddr_i = '0; raddr_i = '0;
      pcM = '0; bad_addrM = '0; data_i = '0;
   endtask

   task automatic nextEdge();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1;
      clearIn();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      validM = 1; we_i = 1; waddr_i = a; data_i = d;
      nextEdge();
      validM = 0; we_i = 0;
   endtask

   task automatic test_reset();
      logic [4:0]  regs [6] = '{5'd12, 5'd13, 5'd14, 5'd8, 5'd9, 5'd11};
      logic [31:0] want [6] = '{32'h0040_0000, 0, 0, 0, 0, 0};
      doReset();
      #1;
      checks++; if ({flush, newpc, excode} !== 38'd0) begin errors++;
         $display("FAIL reset_outputs: got flush=%b newpc=%h excode=%h want all 0", flush, newpc, excode); end
      for (int i = 0; i < 6; i++) begin
         raddr_i = regs[i];
         #1;
         checks++; if (data_o !== want[i]) begin errors++;
            $display("FAIL reset_read_r%0d: got %h want %h", regs[i], data_o, want[i]); end
      end
   endtask

   task automatic test_adel_data();
      doReset();
      validM = 1; adelM = 1; pcM = 32'h8000_0100; bad_addrM = 32'h8000_1001;
      #1;
      checks++; if ({flush, newpc, excode} !== {1'b1, 32'hBFC0_0380, 5'h04}) begin errors++;
         $display("FAIL adel_comb: got flush=%b newpc=%h excode=%h want 1 bfc00380 04", flush, newpc, excode); end
      nextEdge();
      clearIn(); raddr_i = 5'd8;
      #1;
      checks++; if (epc_o !== 32'h8000_0100) begin errors++;
         $display("FAIL adel_epc: got %h want 80000100", epc_o); end
      checks++; if (data_o !== 32'h8000_1001) begin errors++;
         $display("FAIL adel_badvaddr: got %h want 80001001", data_o); end
      checks++; if ({status_o[1], cause_o[31], cause_o[6:2]} !== {1'b1, 1'b0, 5'h04}) begin errors++;
         $display("FAIL adel_exl_bd_code: got %b want 1_0_00100", {status_o[1], cause_o[31], cause_o[6:2]}); end
   endtask

   task automatic test_ades_delay_slot();
      doReset();
      validM = 1; adesM = 1; in_delayslotM = 1; pcM = 32'h8000_0204; bad_addrM = 32'h8000_0ABC;
      #1;
      checks++; if ({flush, excode} !== {1'b1, 5'h05}) begin errors++;
         $display("FAIL ades_comb: got flush=%b excode=%h want 1 05", flush, excode); end
      nextEdge();
      checks++; if ({epc_o, cause_o[31], cause_o[6:2]} !== {32'h8000_0200, 1'b1, 5'h05}) begin errors++;
         $display("FAIL ades_epc_bd: got epc=%h bd=%b code=%h want 80000200 1 05", epc_o, cause_o[31], cause_o[6:2]); end
      in_delayslotM = 0; pcM = 32'h8000_0300; bad_addrM = 32'h8000_0DEF;
      nextEdge();
      clearIn(); raddr_i = 5'd8;
      #1;
      checks++; if ({epc_o, cause_o[31]} !== {32'h8000_0200, 1'b1}) begin errors++;
         $display("FAIL ades_nested_hold: got epc=%h bd=%b want 80000200 1", epc_o, cause_o[31]); end
      checks++; if (data_o !== 32'h8000_0DEF) begin errors++;
         $display("FAIL ades_nested_badvaddr: got %h want 80000def", data_o); end
   endtask

   task automatic test_priority();
      // flags: {ri, sys, bp, ov, adel, ades, eret}; last entry also has a misaligned PC
      logic [6:0] flagTab [6] = '{7'b1100000, 7'b0110000, 7'b0011000, 7'b0000110, 7'b0000011, 7'b1000000};
      logic [4:0] codeTab [6] = '{5'h0a, 5'h08, 5'h09, 5'h04, 5'h05, 5'h04};
      doReset();
      validM = 1;
      for (int i = 0; i < 6; i++) begin
         {riM, syscallM, breakM, overflowM, adelM, adesM, eretM} = flagTab[i];
         pcM = (i == 5) ? 32'h8000_0402 : 32'h8000_0400;
         #1;
         checks++; if ({flush, excode} !== {1'b1, codeTab[i]}) begin errors++;
            $display("FAIL prio_case%0d: got flush=%b excode=%h want 1 %h", i, flush, excode, codeTab[i]); end
      end
      {riM, syscallM, breakM, overflowM, adelM, adesM, eretM} = 7'b0001100;
      pcM = 32'h8000_0400; bad_addrM = 32'h1234_5679;
      #1;
      checks++; if (excode !== 5'h0c) begin errors++;
         $display("FAIL prio_ov_over_adel: got %h want 0c", excode); end
      nextEdge();
      clearIn(); raddr_i = 5'd8; riM = 1;
      #1;
      checks++; if ({data_o, cause_o[6:2]} !== {32'd0, 5'h0c}) begin errors++;
         $display("FAIL prio_ov_badvaddr: got bad=%h code=%h want 0 0c", data_o, cause_o[6:2]); end
      checks++; if ({flush, newpc, excode} !== 38'd0) begin errors++;
         $display("FAIL prio_invalid_ignored: got flush=%b newpc=%h excode=%h want 0", flush, newpc, excode); end
      validM = 1; pcM = 32'h8000_0402;
      nextEdge();
      riM = 0; pcM = 32'h8000_0500; eretM = 1;
      #1;
      checks++; if ({data_o, epc_o} !== {32'h8000_0402, 32'h8000_0400}) begin errors++;
         $display("FAIL prio_fetch_adel: got bad=%h epc=%h want 80000402 80000400", data_o, epc_o); end
      checks++; if ({flush, newpc, excode} !== {1'b1, 32'h8000_0400, 5'h00}) begin errors++;
         $display("FAIL prio_eret_comb: got flush=%b newpc=%h excode=%h want 1 80000400 00", flush, newpc, excode); end
      nextEdge();
      clearIn();
   endtask

   task automatic test_interrupt_eret();
      doReset();
      mtc0(5'd12, 32'h0000_0401);
      int_i = 6'b000001;
      #1;
      checks++; if (flush !== 1'b0) begin errors++;
         $display("FAIL int_not_valid: got flush=%b want 0", flush); end
      nextEdge();
      validM = 1; pcM = 32'h8000_0500;
      #1;
      checks++; if ({flush, newpc, excode, cause_o[10]} !== {1'b1, 32'hBFC0_0380, 5'h00, 1'b1}) begin errors++;
         $display("FAIL int_taken: got flush=%b newpc=%h excode=%h ip2=%b want 1 bfc00380 00 1", flush, newpc, excode, cause_o[10]); end
      nextEdge();
      checks++; if ({status_o, epc_o, flush} !== {32'h0040_0403, 32'h8000_0500, 1'b0}) begin errors++;
         $display("FAIL int_state: got status=%h epc=%h flush=%b want 00400403 80000500 0", status_o, epc_o, flush); end
      eretM = 1;
      #1;
      checks++; if ({flush, newpc, excode} !== {1'b1, 32'h8000_0500, 5'h00}) begin errors++;
         $display("FAIL eret_comb: got flush=%b newpc=%h excode=%h want 1 80000500 00", flush, newpc, excode); end
      nextEdge();
      clearIn();
      checks++; if (status_o !== 32'h0040_0401) begin errors++;
         $display("FAIL eret_exl: got status=%h want 00400401", status_o); end
      nextEdge();
      checks++; if (cause_o[15:8] !== 8'h00) begin errors++;
         $display("FAIL int_ip_clear: got ip=%h want 00", cause_o[15:8]); end
   endtask

   task automatic test_mtc0();
      doReset();
      mtc0(5'd14, 32'h1234_5678);
      mtc0(5'd8, 32'hDEAD_BEEF);
      validM = 1; we_i = 1; waddr_i = 5'd12; data_i = 32'hFFFF_FFFF; raddr_i = 5'd12;
      #1;
      checks++; if (data_o !== 32'h0040_0000) begin errors++;
         $display("FAIL mtc0_no_bypass: got %h want 00400000", data_o); end
      nextEdge();
      mtc0(5'd13, 32'hFFFF_FFFF);
      raddr_i = 5'd8;
      #1;
      checks++; if ({status_o, cause_o, epc_o, data_o} !== {32'h0040_FF03, 32'h0000_0300, 32'h1234_5678, 32'd0}) begin errors++;
         $display("FAIL mtc0_fields: got st=%h ca=%h epc=%h bad=%h want 0040ff03 00000300 12345678 0", status_o, cause_o, epc_o, data_o); end
      raddr_i = 5'd3;
      #1;
      checks++; if (data_o !== 32'd0) begin errors++;
         $display("FAIL mtc0_unimpl_read: got %h want 0", data_o); end
      validM = 1; syscallM = 1; we_i = 1; waddr_i = 5'd14; data_i = 32'hCAFE_0000;
      #1;
      checks++; if ({flush, excode} !== {1'b1, 5'h08}) begin errors++;
         $display("FAIL mtc0_sys_comb: got flush=%b excode=%h want 1 08", flush, excode); end
      nextEdge();
      clearIn();
      checks++; if ({epc_o, cause_o[6:2]} !== {32'h1234_5678, 5'h08}) begin errors++;
         $display("FAIL mtc0_suppressed: got epc=%h code=%h want 12345678 08", epc_o, cause_o[6:2]); end
   endtask

   task automatic test_timer();
      int n;
      logic [31:0] c0;
      doReset();
`ifdef CP0_TIMER_EN
      raddr_i = 5'd9;
      #1 c0 = data_o;
      repeat (10) nextEdge();
      checks++; if (data_o - c0 !== 32'd5) begin errors++;
         $display("FAIL timer_rate: got %0d increments in 10 cycles want 5", data_o - c0); end
      mtc0(5'd11, 32'd5);
      mtc0(5'd9, 32'd0);
      n = 0;
      while (cause_o[30] !== 1'b1 && n < 40) begin
         nextEdge();
         n++;
      end
      checks++; if (n < 10 || n > 11) begin errors++;
         $display("FAIL timer_ti_rise: got TI after %0d cycles want 10..11", n); end
      mtc0(5'd11, 32'd1000);
      checks++; if (cause_o[30] !== 1'b0) begin errors++;
         $display("FAIL timer_ti_clear: got TI=%b want 0", cause_o[30]); end
      mtc0(5'd9, 32'hFFFF_FFFF);
      raddr_i = 5'd9;
      #1;
      checks++; if (data_o !== 32'hFFFF_FFFF) begin errors++;
         $display("FAIL timer_count_write: got %h want ffffffff", data_o); end
      repeat (2) nextEdge();
      checks++; if (data_o !== 32'd0) begin errors++;
         $display("FAIL timer_wrap: got %h want 0", data_o); end
      validM = 1; syscallM = 1; we_i = 1; waddr_i = 5'd11; data_i = 32'd77;
      nextEdge();
      clearIn(); raddr_i = 5'd11;
      #1;
      checks++; if ({data_o, cause_o[6:2]} !== {32'd1000, 5'h08}) begin errors++;
         $display("FAIL timer_compare_suppressed: got cmp=%0d code=%h want 1000 08", data_o, cause_o[6:2]); end
`else
      mtc0(5'd11, 32'd5);
      mtc0(5'd9, 32'd3);
      raddr_i = 5'd9;
      #1 c0 = data_o;
      raddr_i = 5'd11;
      #1;
      checks++; if ({c0, data_o} !== 64'd0) begin errors++;
         $display("FAIL notimer_reads: got count=%h compare=%h want 0 0", c0, data_o); end
      n = 0;
      repeat (20) begin
         nextEdge();
         if (cause_o[30] !== 1'b0) n++;
      end
      checks++; if (n !== 0) begin errors++;
         $display("FAIL notimer_ti: got TI set in %0d cycles want 0", n); end
`endif
   endtask

   task automatic test_async_reset();
      doReset();
      mtc0(5'd12, 32'h0000_0003);
      validM = 1; syscallM = 1; pcM = 32'h8000_0600;
      #1;
      checks++; if (flush !== 1'b1) begin errors++;
         $display("FAIL arst_pre_flush: got %b want 1", flush); end
      rst = 1'b1;
      #1;
      checks++; if ({flush, excode, status_o} !== {1'b0, 5'h00, 32'h0040_0000}) begin errors++;
         $display("FAIL arst_drop: got flush=%b excode=%h status=%h want 0 00 00400000", flush, excode, status_o); end
      clearIn();
      @(posedge clk);
      #1 rst = 1'b0;
      nextEdge();
      checks++; if ({epc_o, cause_o} !== 64'd0) begin errors++;
         $display("FAIL arst_lost: got epc=%h cause=%h want 0 0", epc_o, cause_o); end
   endtask

   task automatic test_random();
      logic        mExl, mIe, mBd, expTaken, expEret, expBadW;
      logic [7:0]  mIm, ipAll;
      logic [5:0]  mIpHw;
      logic [1:0]  mIpSw;
      logic [4:0]  mCode, expCode;
      logic [31:0] mEpc, mBad, expBad, expData, expStatus, expCause, expPc;
      logic [4:0]  rsel [6] = '{5'd8, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
      logic [4:0]  wsel [4] = '{5'd8, 5'd12, 5'd13, 5'd14};
      doReset();
      mExl = 0; mIe = 0; mBd = 0; mIm = 0; mIpHw = 0; mIpSw = 0; mCode = 0; mEpc = 0; mBad = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         validM = ($urandom % 8) != 0;
         pcM = $urandom;
         if ($urandom % 8 != 0) pcM[1:0] = 2'b00;
         in_delayslotM = $urandom % 2;
         bad_addrM = $urandom;
         {riM, syscallM, breakM, overflowM, adelM, adesM, eretM} = '0;
         riM = ($urandom % 12) == 0; syscallM = ($urandom % 12) == 0; breakM = ($urandom % 12) == 0;
         overflowM = ($urandom % 12) == 0; adelM = ($urandom % 10) == 0; adesM = ($urandom % 10) == 0;
         eretM = ($urandom % 6) == 0;
         if ($urandom % 5 == 0) int_i = 6'($urandom) & 6'($urandom);
         we_i = ($urandom % 5) == 0;
         waddr_i = wsel[$urandom % 4];
         data_i = $urandom;
         if (we_i) eretM = 0;
         raddr_i = rsel[$urandom % 6];
         #1;
         ipAll = {mIpHw, mIpSw};
         expTaken = 1; expEret = 0; expBadW = 0; expBad = bad_addrM; expCode = 0;
         if (!validM)                                     expTaken = 0;
         else if (mIe && !mExl && (|(ipAll & mIm)))       expCode = 5'h00;
         else if (pcM[1:0] != 0) begin                    expCode = 5'h04; expBadW = 1; expBad = pcM; end
         else if (riM)                                    expCode = 5'h0a;
         else if (syscallM)                               expCode = 5'h08;
         else if (breakM)                                 expCode = 5'h09;
         else if (overflowM)                              expCode = 5'h0c;
         else if (adelM) begin                            expCode = 5'h04; expBadW = 1; end
         else if (adesM) begin                            expCode = 5'h05; expBadW = 1; end
         else begin expTaken = 0; expEret = eretM; end
         expPc = expTaken ? 32'hBFC0_0380 : (expEret ? mEpc : 32'd0);
         expStatus = 32'h0040_0000 | {16'd0, mIm, 6'd0, mExl, mIe};
         expCause = {mBd, 15'd0, ipAll, 1'b0, mCode, 2'b00};
         case (raddr_i)
            5'd8:    expData = mBad;
            5'd12:   expData = expStatus;
            5'd13:   expData = expCause;
            5'd14:   expData = mEpc;
            default: expData = 32'd0;
         endcase
         checks++; if ({flush, newpc, excode} !== {expTaken | expEret, expPc, expCode}) begin errors++;
            $display("FAIL rand_flush cyc%0d: got %b %h %h want %b %h %h", cyc, flush, newpc, excode,
                     expTaken | expEret, expPc, expCode); end
         checks++; if ({status_o, cause_o, epc_o, data_o} !== {expStatus, expCause, mEpc, expData}) begin errors++;
            $display("FAIL rand_regs cyc%0d: got st=%h ca=%h epc=%h rd=%h want %h %h %h %h", cyc, status_o,
                     cause_o, epc_o, data_o, expStatus, expCause, mEpc, expData); end
         if (expTaken) begin
            if (!mExl) begin mEpc = in_delayslotM ? pcM - 32'd4 : pcM; mBd = in_delayslotM; end
            mExl = 1; mCode = expCode;
            if (expBadW) mBad = expBad;
         end else if (expEret) begin
            mExl = 0;
         end else if (we_i) begin
            case (waddr_i)
               5'd12: begin mIm = data_i[15:8]; mExl = data_i[1]; mIe = data_i[0]; end
               5'd13: mIpSw = data_i[9:8];
               5'd14: mEpc = data_i;
               default: ;
            endcase
         end
         mIpHw = int_i;
         nextEdge();
      end
      clearIn();
   endtask

   initial begin
      rst = 1'b1;
      clearIn();
      test_reset();
      test_adel_data();
      test_ades_delay_slot();
      test_priority();
      test_interrupt_eret();
      test_mtc0();
      test_timer();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
